param_pipe_reg: RTL and testbench



---
 rtl/param_pipe_reg_pkg.sv | 14 +
 rtl/param_pipe_slice.sv | 58 +++++
 rtl/param_pipe_reg.sv | 72 +++++++
 tb/tb_param_pipe_reg.sv | 214 +++++++++++++++++++++
 4 files changed

// File: rtl/param_pipe_reg_pkg.sv
// Shared types and helpers for the elastic pipeline register and its slices.
package param_pipe_reg_pkg;

  // Occupancy counter width for a chain holding up to 2*depth words.
  function automatic int cw_of(input int depth);
    return $clog2(2 * depth + 1);
  endfunction

  typedef struct packed {
    logic mv;
    logic sv;
  } slice_state_t;

endpackage

// File: rtl/param_pipe_slice.sv
// One skid-buffer slice: registered ready, main register drives the output,
// skid register absorbs the word that arrives while main is stalled.
module param_pipe_slice
  import param_pipe_reg_pkg::*;
#(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         flush,
  input  logic         s_valid,
  output logic         s_ready,
  input  logic [W-1:0] s_data,
  output logic         m_valid,
  input  logic         m_ready,
  output logic [W-1:0] m_data
);

  slice_state_t st;
  logic [W-1:0] md;
  logic [W-1:0] sd;
  logic         in_x;
  logic         out_x;

  assign s_ready = !st.sv && !flush;
  assign m_valid = st.mv && !flush;
  assign m_data  = md;
  assign in_x    = s_valid && s_ready;
  assign out_x   = m_valid && m_ready;

  always_ff @(posedge clk) begin
    if (reset) begin
      st <= '0;
      md <= '0;
      sd <= '0;
    end else if (flush) begin
      st <= '0;
    end else if (out_x) begin
      if (st.sv) begin
        md    <= sd;
        st.sv <= 1'b0;
      end else if (in_x) begin
        md <= s_data;
      end else begin
        st.mv <= 1'b0;
      end
    end else if (in_x) begin
      if (!st.mv) begin
        md    <= s_data;
        st.mv <= 1'b1;
      end else begin
        sd    <= s_data;
        st.sv <= 1'b1;
      end
    end
  end

endmodule

// File: rtl/param_pipe_reg.sv
// Elastic pipeline register: DEPTH chained skid slices with an occupancy count.
// Optional synchronous flush port enabled by defining PARAM_PIPE_REG_FLUSH_EN.
module param_pipe_reg
  import param_pipe_reg_pkg::*;
#(
  parameter  int W     = 8,
  parameter  int DEPTH = 2,
  localparam int CW    = cw_of(DEPTH)
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          s_valid,
  output logic          s_ready,
  input  logic [W-1:0]  s_data,
  output logic          m_valid,
  input  logic          m_ready,
  output logic [W-1:0]  m_data,
`ifdef PARAM_PIPE_REG_FLUSH_EN
  input  logic          flush,
`endif
  output logic [CW-1:0] count
);

`ifndef PARAM_PIPE_REG_FLUSH_EN
  logic flush;
  assign flush = 1'b0;
`endif

  logic         v [DEPTH+1];
  logic         r [DEPTH+1];
  logic [W-1:0] d [DEPTH+1];
  logic         in_x;
  logic         out_x;

  assign v[0]     = s_valid;
  assign d[0]     = s_data;
  assign s_ready  = r[0];
  assign m_valid  = v[DEPTH];
  assign m_data   = d[DEPTH];
  assign r[DEPTH] = m_ready;

  for (genvar k = 0; k < DEPTH; k++) begin : g_slice
    param_pipe_slice #(.W(W)) u_slice (
      .clk    (clk),
      .reset  (reset),
      .flush  (flush),
      .s_valid(v[k]),
      .s_ready(r[k]),
      .s_data (d[k]),
      .m_valid(v[k+1]),
      .m_ready(r[k+1]),
      .m_data (d[k+1])
    );
  end

  assign in_x  = s_valid && s_ready;
  assign out_x = m_valid && m_ready;

  // Occupancy tracks boundary transfers only; internal hops do not change it.
  always_ff @(posedge clk) begin
    if (reset || flush) begin
      count <= '0;
    end else begin
      case ({in_x, out_x})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

endmodule

// File: tb/tb_param_pipe_reg.sv
// Directed and randomized checks of param_pipe_reg against a queue-based model.
module tb_param_pipe_reg;
  localparam int W     = 8;
  localparam int DEPTH = 2;
  localparam int CW    = $clog2(2 * DEPTH + 1);

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic          s_valid = 1'b0;
  logic          s_ready;
  logic [W-1:0]  s_data = '0;
  logic          m_valid;
  logic          m_ready = 1'b0;
  logic [W-1:0]  m_data;
  logic [CW-1:0] count;
`ifdef PARAM_PIPE_REG_FLUSH_EN
  logic          flush = 1'b0;
`endif

  always #5 clk = ~clk;

  param_pipe_reg #(.W(W), .DEPTH(DEPTH)) dut (
    .clk    (clk),
    .reset  (reset),
    .s_valid(s_valid),
    .s_ready(s_ready),
    .s_data (s_data),
    .m_valid(m_valid),
    .m_ready(m_ready),
    .m_data (m_data),
`ifdef PARAM_PIPE_REG_FLUSH_EN
    .flush  (flush),
`endif
    .count  (count)
  );

  typedef struct {
    logic [W-1:0] d;
    int           c;
  } ent_t;

  ent_t q[$];
  int   vectors = 0;
  int   miscompares = 0;
  int   cyc = 0;
  logic last_in, last_out, last_sr, last_mv;
  logic [W-1:0] last_md;
  bit   exact_lat = 1'b0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // One clock: drive, sample pre-edge handshake, update the queue model, check.
  task automatic cycle(input logic sv, input logic [W-1:0] sd, input logic mr);
    ent_t e;
    @(negedge clk);
    reset = 1'b0; s_valid = sv; s_data = sd; m_ready = mr;
    #1;
    last_sr  = s_ready;
    last_mv  = m_valid;
    last_md  = m_data;
    last_in  = s_valid && s_ready;
    last_out = m_valid && m_ready;
    @(posedge clk);
    cyc++;
    #1;
    if (last_out) begin
      if (q.size() == 0) begin
        chk("unexpected_output", {24'd0, last_md}, 32'hDEAD);
      end else begin
        e = q.pop_front();
        chk("order", {24'd0, last_md}, {24'd0, e.d});
        if (exact_lat) chk("latency", cyc - e.c, DEPTH);
        else           chk("min_latency", 32'(cyc - e.c >= DEPTH), 1);
      end
    end
    if (last_in) begin
      e.d = sd; e.c = cyc;
      q.push_back(e);
    end
    chk("count", {29'd0, count}, q.size());
  endtask

  task automatic drain();
    int n = 0;
    while (q.size() != 0 && n < 50) begin
      cycle(1'b0, '0, 1'b1);
      n++;
    end
    chk("drain_done", q.size(), 0);
  endtask

  initial begin
    logic [W-1:0] idx;
    logic         rv;
    logic [W-1:0] rd;
    logic         prev_hold;
    logic [W-1:0] prev_md;

    // Power-up reset
    repeat (2) @(posedge clk);
    #1;
    chk("rst_m_valid", {31'd0, m_valid}, 0);
    chk("rst_m_data", {24'd0, m_data}, 0);
    chk("rst_s_ready", {31'd0, s_ready}, 1);
    chk("rst_count", {29'd0, count}, 0);

    // Single word 0xA5
    exact_lat = 1'b1;
    cycle(1'b1, 8'hA5, 1'b1);
    chk("a5_mv_edge1", {31'd0, m_valid}, 0);
    chk("a5_cnt_edge1", {29'd0, count}, 1);
    cycle(1'b0, '0, 1'b1);
    chk("a5_mv_edge2", {31'd0, m_valid}, 1);
    chk("a5_md_edge2", {24'd0, m_data}, 32'hA5);
    cycle(1'b0, '0, 1'b1);
    chk("a5_cnt_after", {29'd0, count}, 0);
    chk("a5_mv_after", {31'd0, m_valid}, 0);

    // Back-to-back stream 0x00..0x0F
    for (int i = 0; i < 16; i++) begin
      cycle(1'b1, W'(i), 1'b1);
      chk("stream_s_ready", {31'd0, last_sr}, 1);
    end
    drain();
    exact_lat = 1'b0;

    // Backpressure: offer 0x01..0x05 with m_ready low
    idx = 8'h01;
    for (int i = 0; i < 6; i++) begin
      cycle(1'b1, idx, 1'b0);
      if (last_in) idx++;
    end
    chk("bp_accepted_next", {24'd0, idx}, 5);
    chk("bp_s_ready", {31'd0, s_ready}, 0);
    chk("bp_count", {29'd0, count}, 4);
    for (int i = 0; i < 10 && idx != 8'h06; i++) begin
      cycle(1'b1, idx, 1'b1);
      if (last_in) idx++;
    end
    chk("bp_all_accepted", {24'd0, idx}, 6);
    drain();

    // Random traffic with upstream holding offered words until accepted
    rv = 1'b0; rd = '0; prev_hold = 1'b0; prev_md = '0;
    for (int i = 0; i < 10000; i++) begin
      if (!(rv && !last_in)) begin
        rv = 1'($urandom_range(0, 1));
        rd = W'($urandom);
      end
      cycle(rv, rd, 1'($urandom_range(0, 1)));
      chk("cap", 32'(count <= 2 * DEPTH), 1);
      if (last_mv) chk("mv_has_word", 32'(q.size() + (last_out ? 1 : 0) > 0), 1);
      if (prev_hold) begin
        chk("hold_valid", {31'd0, last_mv}, 1);
        chk("hold_data", {24'd0, last_md}, {24'd0, prev_md});
      end
      prev_hold = last_mv && !last_out;
      prev_md   = last_md;
    end
    drain();

    // Reset mid-operation with three words held
    for (int i = 0; i < 3; i++) cycle(1'b1, W'(8'h50 + i), 1'b0);
    chk("pre_reset_count", {29'd0, count}, 3);
    @(negedge clk);
    reset = 1'b1; s_valid = 1'b1; m_ready = 1'b1;
    @(posedge clk);
    #1;
    q.delete();
    chk("mid_rst_m_valid", {31'd0, m_valid}, 0);
    chk("mid_rst_m_data", {24'd0, m_data}, 0);
    chk("mid_rst_s_ready", {31'd0, s_ready}, 1);
    chk("mid_rst_count", {29'd0, count}, 0);
    for (int i = 0; i < 8; i++) cycle(1'b0, '0, 1'b1);

`ifdef PARAM_PIPE_REG_FLUSH_EN
    // Flush with a full pipe
    for (int i = 0; i < 6; i++) cycle(1'b1, W'(8'h60 + i), 1'b0);
    chk("pre_flush_count", {29'd0, count}, 4);
    @(negedge clk);
    flush = 1'b1; s_valid = 1'b1; s_data = 8'h77; m_ready = 1'b1;
    #1;
    chk("flush_s_ready", {31'd0, s_ready}, 0);
    chk("flush_m_valid", {31'd0, m_valid}, 0);
    @(posedge clk);
    #1;
    q.delete();
    flush = 1'b0;
    chk("post_flush_count", {29'd0, count}, 0);
    exact_lat = 1'b1;
    cycle(1'b1, 8'h3C, 1'b1);
    cycle(1'b0, '0, 1'b1);
    chk("flush_new_mv", {31'd0, m_valid}, 1);
    chk("flush_new_md", {24'd0, m_data}, 32'h3C);
    drain();
    exact_lat = 1'b0;
`endif

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: observed timeout expected completion");
    $fatal(1, "watchdog expired");
  end
endmodule
